// File: rtl/muldiv_prenorm_if.sv
// Operand/result bundle between the register-file read stage, muldiv_prenorm
// and the mantissa mul/div datapath.
interface muldiv_prenorm_if #(
  parameter int NUM_BITS   = 16,
  parameter int EXP_WIDTH  = 5,
  parameter int MANT_WIDTH = 10
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        op;
  logic [NUM_BITS-1:0]         a_src;
  logic [NUM_BITS-1:0]         b_src;
  logic                        out_valid;
  logic                        out_ready;
  logic                        arithmetic;
  logic [NUM_BITS-1:0]         direct_result;
  logic                        sign;
  logic [MANT_WIDTH:0]         mant_a;
  logic [MANT_WIDTH:0]         mant_b;
  logic signed [EXP_WIDTH+1:0] exp_a;
  logic signed [EXP_WIDTH+1:0] exp_b;
  logic                        zero;
  logic                        inf;
  logic                        qnan;
  logic                        invalid;
  logic                        dz;
  logic [1:0]                  fsm_state;

  modport master (
    output in_valid, op, a_src, b_src, out_ready,
    input  in_ready, out_valid, arithmetic, direct_result, sign,
           mant_a, mant_b, exp_a, exp_b, zero, inf, qnan, invalid, dz, fsm_state
  );

  modport slave (
    input  in_valid, op, a_src, b_src, out_ready,
    output in_ready, out_valid, arithmetic, direct_result, sign,
           mant_a, mant_b, exp_a, exp_b, zero, inf, qnan, invalid, dz, fsm_state
  );
endinterface

// File: rtl/muldiv_prenorm.sv
// Multiply/divide pre-normalisation: classifies operands, resolves special cases,
// normalises subnormal significands. Divide rules enabled by MULDIV_PRENORM_DIV_EN.
module muldiv_prenorm #(
    parameter int NUM_BITS   = 16,
    parameter int EXP_WIDTH  = 5,
    parameter int MANT_WIDTH = 10,
    parameter int BIAS       = 15
) (
    input logic           clk,
    input logic           rst_n,
    muldiv_prenorm_if.slave bus
);

    localparam int EW2 = EXP_WIDTH + 2;
    localparam logic signed [EW2-1:0] BIAS_S  = EW2'(BIAS);
    localparam logic signed [EW2-1:0] SUB_EXP = EW2'(1 - BIAS);
    localparam logic signed [EW2-1:0] ONE_S   = EW2'(1);
    localparam logic [NUM_BITS-1:0] QUIET_BIT =
        {{(NUM_BITS - MANT_WIDTH){1'b0}}, 1'b1, {(MANT_WIDTH - 1){1'b0}}};
    localparam logic [NUM_BITS-1:0] CANON_NAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        NORM = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                 state;
    logic [NUM_BITS-1:0]    a_r, b_r;
`ifdef MULDIV_PRENORM_DIV_EN
    logic                   op_r;
`endif
    logic                   in_ready_r, out_valid_r, arith_r, sign_r;
    logic [NUM_BITS-1:0]    direct_r;
    logic [MANT_WIDTH:0]    mant_a_r, mant_b_r;
    logic signed [EW2-1:0]  exp_a_r, exp_b_r;
    logic                   zero_r, inf_r, qnan_r, invalid_r, dz_r;

    // Field decode of the captured operands
    logic [EXP_WIDTH-1:0]   a_e, b_e;
    logic [MANT_WIDTH-1:0]  a_f, b_f;
    logic a_inf, a_qnan, a_snan, a_zero, a_sub;
    logic b_inf, b_qnan, b_snan, b_zero, b_sub;
    logic d_sign;

    assign a_e = a_r[NUM_BITS-2 -: EXP_WIDTH];
    assign b_e = b_r[NUM_BITS-2 -: EXP_WIDTH];
    assign a_f = a_r[MANT_WIDTH-1:0];
    assign b_f = b_r[MANT_WIDTH-1:0];

    assign a_inf  = (&a_e) && (a_f == '0);
    assign a_qnan = (&a_e) && a_f[MANT_WIDTH-1];
    assign a_snan = (&a_e) && !a_f[MANT_WIDTH-1] && (a_f != '0);
    assign a_zero = (a_e == '0) && (a_f == '0);
    assign a_sub  = (a_e == '0) && (a_f != '0);
    assign b_inf  = (&b_e) && (b_f == '0);
    assign b_qnan = (&b_e) && b_f[MANT_WIDTH-1];
    assign b_snan = (&b_e) && !b_f[MANT_WIDTH-1] && (b_f != '0);
    assign b_zero = (b_e == '0) && (b_f == '0);
    assign b_sub  = (b_e == '0) && (b_f != '0);
    assign d_sign = a_r[NUM_BITS-1] ^ b_r[NUM_BITS-1];

    logic [NUM_BITS-1:0] inf_val, zero_val;
    assign inf_val  = {d_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    assign zero_val = {d_sign, {(NUM_BITS - 1){1'b0}}};

    // Special-case resolution, first match wins
    logic                d_arith, d_zero, d_inf, d_qnan, d_invalid, d_dz;
    logic [NUM_BITS-1:0] d_direct;

    always_comb begin
        d_arith   = 1'b0;
        d_zero    = 1'b0;
        d_inf     = 1'b0;
        d_qnan    = 1'b0;
        d_invalid = 1'b0;
        d_dz      = 1'b0;
        d_direct  = '0;
        if (a_snan) begin
            d_direct  = a_r | QUIET_BIT;
            d_qnan    = 1'b1;
            d_invalid = 1'b1;
        end else if (b_snan) begin
            d_direct  = b_r | QUIET_BIT;
            d_qnan    = 1'b1;
            d_invalid = 1'b1;
        end else if (a_qnan) begin
            d_direct = a_r;
            d_qnan   = 1'b1;
        end else if (b_qnan) begin
            d_direct = b_r;
            d_qnan   = 1'b1;
        end
`ifdef MULDIV_PRENORM_DIV_EN
        else if (op_r) begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                d_direct  = CANON_NAN;
                d_qnan    = 1'b1;
                d_invalid = 1'b1;
            end else if (a_inf) begin
                d_direct = inf_val;
                d_inf    = 1'b1;
            end else if (b_zero) begin
                d_direct = inf_val;
                d_inf    = 1'b1;
                d_dz     = 1'b1;
            end else if (a_zero || b_inf) begin
                d_direct = zero_val;
                d_zero   = 1'b1;
            end else begin
                d_arith = 1'b1;
            end
        end
`endif
        else begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                d_direct  = CANON_NAN;
                d_qnan    = 1'b1;
                d_invalid = 1'b1;
            end else if (a_inf || b_inf) begin
                d_direct = inf_val;
                d_inf    = 1'b1;
            end else if (a_zero || b_zero || (a_sub && b_sub)) begin
                d_direct = zero_val;
                d_zero   = 1'b1;
            end else begin
                d_arith = 1'b1;
            end
        end
    end

    // Initial significand/exponent; subnormals carry a zero hidden bit
    logic [MANT_WIDTH:0]   mant_a0, mant_b0;
    logic signed [EW2-1:0] exp_a0, exp_b0;
    assign mant_a0 = {!a_sub, a_f};
    assign mant_b0 = {!b_sub, b_f};
    assign exp_a0  = a_sub ? SUB_EXP : ($signed({2'b00, a_e}) - BIAS_S);
    assign exp_b0  = b_sub ? SUB_EXP : ($signed({2'b00, b_e}) - BIAS_S);

    // Looking one shift ahead lets NORM leave on the same edge as its final shift
    logic norm_done;
    assign norm_done = (mant_a_r[MANT_WIDTH] || mant_a_r[MANT_WIDTH-1]) &&
                       (mant_b_r[MANT_WIDTH] || mant_b_r[MANT_WIDTH-1]);

    // Handshake: a transfer happens on any rising edge where valid && ready are
    // both high; valid never drops and payload never changes until that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
`ifdef MULDIV_PRENORM_DIV_EN
            op_r        <= 1'b0;
`endif
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            arith_r     <= 1'b0;
            sign_r      <= 1'b0;
            direct_r    <= '0;
            mant_a_r    <= '0;
            mant_b_r    <= '0;
            exp_a_r     <= '0;
            exp_b_r     <= '0;
            zero_r      <= 1'b0;
            inf_r       <= 1'b0;
            qnan_r      <= 1'b0;
            invalid_r   <= 1'b0;
            dz_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a_src;
                        b_r        <= bus.b_src;
`ifdef MULDIV_PRENORM_DIV_EN
                        op_r       <= bus.op;
`endif
                        in_ready_r <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    arith_r   <= d_arith;
                    sign_r    <= d_sign;
                    direct_r  <= d_direct;
                    zero_r    <= d_zero;
                    inf_r     <= d_inf;
                    qnan_r    <= d_qnan;
                    invalid_r <= d_invalid;
                    dz_r      <= d_dz;
                    if (d_arith) begin
                        mant_a_r <= mant_a0;
                        mant_b_r <= mant_b0;
                        exp_a_r  <= exp_a0;
                        exp_b_r  <= exp_b0;
                    end else begin
                        mant_a_r <= '0;
                        mant_b_r <= '0;
                        exp_a_r  <= '0;
                        exp_b_r  <= '0;
                    end
                    if (d_arith && (a_sub || b_sub)) begin
                        state <= NORM;
                    end else begin
                        state       <= HOLD;
                        out_valid_r <= 1'b1;
                    end
                end
                NORM: begin
                    if (!mant_a_r[MANT_WIDTH]) begin
                        mant_a_r <= mant_a_r << 1;
                        exp_a_r  <= exp_a_r - ONE_S;
                    end
                    if (!mant_b_r[MANT_WIDTH]) begin
                        mant_b_r <= mant_b_r << 1;
                        exp_b_r  <= exp_b_r - ONE_S;
                    end
                    if (norm_done) begin
                        state       <= HOLD;
                        out_valid_r <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.arithmetic    = arith_r;
    assign bus.direct_result = direct_r;
    assign bus.sign          = sign_r;
    assign bus.mant_a        = mant_a_r;
    assign bus.mant_b        = mant_b_r;
    assign bus.exp_a         = exp_a_r;
    assign bus.exp_b         = exp_b_r;
    assign bus.zero          = zero_r;
    assign bus.inf           = inf_r;
    assign bus.qnan          = qnan_r;
    assign bus.invalid       = invalid_r;
    assign bus.dz            = dz_r;
    assign bus.fsm_state     = state;

endmodule
